// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALUOp classes, main-control bundle,
// register specifier width. Used by main control, ALUcontrol and the
// pipeline registers.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 9;

    localparam logic [1:0] ALUOP_LWSW  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Main-control bundle as produced in ID; packed so it can ride through
    // a plain vector register.
    typedef struct packed {
        logic       RegWrite;
        logic       MemtoReg;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       RegDst;
        logic       ALUSrc;
        logic [1:0] ALUOp;
    } ctrl_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: hazard controls, ID-side fields and their EX-side
// registered copies. master = ID/hazard side, slave = the pipeline register.
interface id_ex_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    import mips_pkg::*;

    logic                  stall;
    logic                  flush;
    logic                  valid_id;
    logic                  RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id;
    logic                  Branch_id, RegDst_id, ALUSrc_id;
    logic [1:0]            ALUOp_id;
    logic [DATA_W-1:0]     PCplus4_id, ReadData1_id, ReadData2_id, SignImm_id;
    logic [REG_ADDR_W-1:0] Rs_id, Rt_id, Rd_id;

    logic                  valid_ex;
    logic                  RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex;
    logic                  Branch_ex, RegDst_ex, ALUSrc_ex;
    logic [1:0]            ALUOp_ex;
    logic [DATA_W-1:0]     PCplus4_ex, ReadData1_ex, ReadData2_ex, SignImm_ex;
    logic [REG_ADDR_W-1:0] Rs_ex, Rt_ex, Rd_ex;
    logic [5:0]            funct_ex;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output stall, flush, valid_id,
        output RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id,
        output Branch_id, RegDst_id, ALUSrc_id, ALUOp_id,
        output PCplus4_id, ReadData1_id, ReadData2_id, SignImm_id,
        output Rs_id, Rt_id, Rd_id,
        input  valid_ex,
        input  RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex,
        input  Branch_ex, RegDst_ex, ALUSrc_ex, ALUOp_ex,
        input  PCplus4_ex, ReadData1_ex, ReadData2_ex, SignImm_ex,
        input  Rs_ex, Rt_ex, Rd_ex, funct_ex, bubble_cnt
    );

    modport slave (
        input  stall, flush, valid_id,
        input  RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id,
        input  Branch_id, RegDst_id, ALUSrc_id, ALUOp_id,
        input  PCplus4_id, ReadData1_id, ReadData2_id, SignImm_id,
        input  Rs_id, Rt_id, Rd_id,
        output valid_ex,
        output RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex,
        output Branch_ex, RegDst_ex, ALUSrc_ex, ALUOp_ex,
        output PCplus4_ex, ReadData1_ex, ReadData2_ex, SignImm_ex,
        output Rs_ex, Rt_ex, Rd_ex, funct_ex, bubble_cnt
    );

endinterface

// File: rtl/pipe_field_reg.sv
// One field group of a pipeline register: clears on reset or flush,
// holds on stall, otherwise loads.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         stall,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset and flush both produce an all-zero bubble, so they share a branch.
    always_ff @(posedge clk) begin
        if (reset || flush) q <= '0;
        else if (!stall)    q <= d;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall/flush and a saturating bubble counter.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         reset,
    id_ex_reg_if.slave  bus
);

    localparam int CW = CTRL_W + 1;
    localparam int DW = 4 * DATA_W;
    localparam int SW = 3 * REG_ADDR_W;

    ctrl_t             ctrl_id, ctrl_ex;
    logic              valid_q;
    logic [CW-1:0]     ctrl_q;
    logic [DW-1:0]     data_q;
    logic [SW-1:0]     spec_q;
    logic [CNT_W-1:0]  cnt_q;

    assign ctrl_id = {bus.RegWrite_id, bus.MemtoReg_id, bus.MemRead_id,
                      bus.MemWrite_id, bus.Branch_id, bus.RegDst_id,
                      bus.ALUSrc_id, bus.ALUOp_id};

    // valid travels with control so a flush kills both together
    pipe_field_reg #(.W(CW)) u_ctrl (
        .clk(clk), .reset(reset), .flush(bus.flush), .stall(bus.stall),
        .d({bus.valid_id, ctrl_id}), .q(ctrl_q)
    );

    pipe_field_reg #(.W(DW)) u_data (
        .clk(clk), .reset(reset), .flush(bus.flush), .stall(bus.stall),
        .d({bus.PCplus4_id, bus.ReadData1_id, bus.ReadData2_id, bus.SignImm_id}),
        .q(data_q)
    );

    pipe_field_reg #(.W(SW)) u_spec (
        .clk(clk), .reset(reset), .flush(bus.flush), .stall(bus.stall),
        .d({bus.Rs_id, bus.Rt_id, bus.Rd_id}),
        .q(spec_q)
    );

    // Count applied flushes; pins at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset)                          cnt_q <= '0;
        else if (bus.flush && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end

    assign {valid_q, ctrl_ex} = ctrl_q;

    assign bus.valid_ex    = valid_q;
    assign bus.RegWrite_ex = ctrl_ex.RegWrite;
    assign bus.MemtoReg_ex = ctrl_ex.MemtoReg;
    assign bus.MemRead_ex  = ctrl_ex.MemRead;
    assign bus.MemWrite_ex = ctrl_ex.MemWrite;
    assign bus.Branch_ex   = ctrl_ex.Branch;
    assign bus.RegDst_ex   = ctrl_ex.RegDst;
    assign bus.ALUSrc_ex   = ctrl_ex.ALUSrc;
    assign bus.ALUOp_ex    = ctrl_ex.ALUOp;

    assign {bus.PCplus4_ex, bus.ReadData1_ex, bus.ReadData2_ex, bus.SignImm_ex} = data_q;
    assign {bus.Rs_ex, bus.Rt_ex, bus.Rd_ex} = spec_q;

    // funct is just the low immediate bits, already registered
    assign bus.funct_ex   = bus.SignImm_ex[5:0];
    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg, plus hand sequences for
// counter saturation and input-to-output isolation.
module tb_id_ex_reg;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs, rt, rd;
    } fld_t;

    typedef struct packed {
        logic       rst, stall, flush;
        fld_t       in;
        fld_t       exp;
        logic [5:0] exp_funct;
        logic [3:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    function automatic ctrl_t mkc(input logic rw, mr2r, mrd, mwr, br, rdst, asrc,
                                  input logic [1:0] op);
        ctrl_t c;
        c = {rw, mr2r, mrd, mwr, br, rdst, asrc, op};
        return c;
    endfunction

    function automatic fld_t mkf(input logic v, input ctrl_t c,
                                 input logic [31:0] pc, r1, r2, imm,
                                 input logic [4:0] rs, rt, rd);
        fld_t f;
        f = {v, c, pc, r1, r2, imm, rs, rt, rd};
        return f;
    endfunction

    task automatic drive(input logic rst, stall, flush, input fld_t f);
        reset            = rst;
        bus.stall        = stall;
        bus.flush        = flush;
        bus.valid_id     = f.valid;
        bus.RegWrite_id  = f.ctrl.RegWrite;
        bus.MemtoReg_id  = f.ctrl.MemtoReg;
        bus.MemRead_id   = f.ctrl.MemRead;
        bus.MemWrite_id  = f.ctrl.MemWrite;
        bus.Branch_id    = f.ctrl.Branch;
        bus.RegDst_id    = f.ctrl.RegDst;
        bus.ALUSrc_id    = f.ctrl.ALUSrc;
        bus.ALUOp_id     = f.ctrl.ALUOp;
        bus.PCplus4_id   = f.pc;
        bus.ReadData1_id = f.r1;
        bus.ReadData2_id = f.r2;
        bus.SignImm_id   = f.imm;
        bus.Rs_id        = f.rs;
        bus.Rt_id        = f.rt;
        bus.Rd_id        = f.rd;
    endtask

    function automatic fld_t sample();
        fld_t f;
        f = mkf(bus.valid_ex,
                mkc(bus.RegWrite_ex, bus.MemtoReg_ex, bus.MemRead_ex, bus.MemWrite_ex,
                    bus.Branch_ex, bus.RegDst_ex, bus.ALUSrc_ex, bus.ALUOp_ex),
                bus.PCplus4_ex, bus.ReadData1_ex, bus.ReadData2_ex, bus.SignImm_ex,
                bus.Rs_ex, bus.Rt_ex, bus.Rd_ex);
        return f;
    endfunction

    task automatic chk_fld(input string name, input fld_t act, input fld_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[13];
    fld_t ones, zero, ra, lw, inv;

    initial begin
        ones = '1;
        zero = '0;
        // add-class R-type: funct 0x20
        ra   = mkf(1'b1, mkc(1, 0, 0, 0, 0, 1, 0, ALUOP_RTYPE),
                   32'h0000_0104, 32'h0000_0011, 32'h0000_0022, 32'h0000_0020,
                   5'd1, 5'd2, 5'd3);
        // lw with offset 4
        lw   = mkf(1'b1, mkc(1, 1, 1, 0, 0, 0, 1, ALUOP_LWSW),
                   32'h0000_0108, 32'h0000_1000, 32'h0000_0005, 32'h0000_0004,
                   5'd4, 5'd5, 5'd0);
        // invalid slot carrying stray control bits; must pass through unmasked
        inv  = mkf(1'b0, mkc(0, 0, 0, 1, 1, 0, 0, ALUOP_BEQ),
                   32'h0000_010C, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFFB,
                   5'd31, 5'd17, 5'd9);

        //            rst  stl  fls  in    exp   funct   cnt
        vecs[0]  = '{1'b1, 1'b1, 1'b1, ones, zero, 6'h00, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, ones, zero, 6'h00, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, ra,   ra,   6'h20, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, lw,   lw,   6'h04, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, zero, lw,   6'h04, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, zero, lw,   6'h04, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, zero, lw,   6'h04, 4'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, ra,   zero, 6'h00, 4'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, ra,   ra,   6'h20, 4'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, lw,   zero, 6'h00, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, inv,  inv,  6'h3B, 4'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b1, lw,   zero, 6'h00, 4'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, lw,   lw,   6'h04, 4'd0};

        drive(1'b1, 1'b0, 1'b0, zero);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].in);
            @(posedge clk);
            #1;
            chk_fld($sformatf("v%0d_fields", i), sample(), vecs[i].exp);
            chk_val($sformatf("v%0d_funct", i), 32'(bus.funct_ex), 32'(vecs[i].exp_funct));
            chk_val($sformatf("v%0d_cnt", i), 32'(bus.bubble_cnt), 32'(vecs[i].exp_cnt));
        end

        // outputs must not follow inputs between edges
        drive(1'b0, 1'b0, 1'b0, ra);
        #3;
        chk_fld("no_comb_path", sample(), lw);
        @(posedge clk);
        #1;
        chk_fld("load_after_isolation", sample(), ra);

        // 20 back-to-back flushes from a fresh reset: counter pins at 15
        drive(1'b1, 1'b0, 1'b0, zero);
        @(posedge clk);
        #1;
        chk_val("sat_reset_cnt", 32'(bus.bubble_cnt), 32'd0);
        for (int n = 1; n <= 20; n++) begin
            drive(1'b0, 1'b0, 1'b1, ra);
            @(posedge clk);
            #1;
            chk_val($sformatf("sat_cnt_%0d", n), 32'(bus.bubble_cnt),
                    (n > 15) ? 32'd15 : 32'(n));
        end
        chk_fld("sat_fields_zero", sample(), zero);

        // stall alone keeps the saturated count
        drive(1'b0, 1'b1, 1'b0, ra);
        @(posedge clk);
        #1;
        chk_val("sat_hold_on_stall", 32'(bus.bubble_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between instruction decode (ID) and execute (EX) in the 5-stage MIPS datapath. It captures the main-control bundle, register-file read data, sign-extended immediate, register specifiers and PC+4 at each rising edge, and presents them to EX. Its ALUOp/funct outputs drive ALUcontrol. It supports stall (hold) and flush (bubble insert) from the hazard unit, and keeps a saturating count of inserted bubbles for debug.

## Interface
Parameters:
- DATA_W, 32, width of data, PC and immediate paths
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising clk edge only
- stall  in  1  hold all EX-side contents
- flush  in  1  load a bubble (all control zero, valid_ex=0)
- valid_id  in  1  ID holds a real instruction
- RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, Branch_id, RegDst_id, ALUSrc_id  in  1 each  main control bits
- ALUOp_id  in  2  ALU operation class
- PCplus4_id, ReadData1_id, ReadData2_id, SignImm_id  in  DATA_W  datapath values
- Rs_id, Rt_id, Rd_id  in  5  register specifiers
- same-named *_ex outputs, same widths, registered copies of the above
- funct_ex  out  6  SignImm_ex[5:0], to ALUcontrol
- valid_ex  out  1  EX holds a real instruction
- bubble_cnt  out  CNT_W  number of flushes applied since reset

## Operation
- Per-edge priority: reset > flush > stall > load.
- reset: every output register, including bubble_cnt and valid_ex, goes to 0.
- flush (reset low): all control outputs, ALUOp_ex and valid_ex become 0; all data, specifier and funct outputs become 0. bubble_cnt increments by 1, saturating at 2^CNT_W-1 (stays there, no wrap).
- flush with stall both high: flush wins and stall is ignored. The hazard unit must never rely on holding through a flush.
- stall (no reset, no flush): every output holds its value; bubble_cnt unchanged.
- load (none of the above): every *_ex output takes its *_id input; valid_ex <= valid_id. funct_ex is wired from the registered SignImm_ex[5:0] and is not separately registered.
- valid_id=0 on load: fields are captured as presented. ID is responsible for zeroing control on invalid slots. The block does not mask them.
- No FSM beyond a 1-deep register plus the counter. State is the register contents and bubble_cnt.

## Timing
- Latency: exactly 1 cycle from *_id to *_ex on a load edge.
- All outputs are registered. No combinational path from any input to any output.
- stall/flush take effect at the same edge at which they are sampled high.
- Reset mid-stream discards the in-flight instruction in the same cycle. The first load after reset deasserts captures normally.
- After reset, bubble_cnt reads 0 until the first flush edge, then reads 1 in the following cycle.

## Structure
- Shared package (mips_pkg): ALUOp encodings (ALUOP_LWSW=2'b00, ALUOP_BEQ=2'b01, ALUOP_RTYPE=2'b10), the control-bundle struct/width constant (CTRL_W=9), and REG_ADDR_W=5. ALUcontrol and the main control unit use the same package.
- Natural sub-module: pipe_field_reg. This is a parameterised-width register with reset/flush-to-zero, stall-hold and load, instantiated once per field group (control, data, specifiers). The bubble counter stays in the top module.

## Test plan
- Reset: assert reset with all inputs 0xFFFFFFFF/1 for 2 cycles -> all outputs 0, bubble_cnt=0, valid_ex=0.
- Load R-type: ALUOp_id=2'b10, SignImm_id=0x00000020, RegWrite_id=1, RegDst_id=1, valid_id=1 -> next cycle ALUOp_ex=2'b10, funct_ex=6'h20, RegWrite_ex=1, valid_ex=1.
- Stall: load lw (MemRead_id=1, ALUSrc_id=1, SignImm_id=0x4), then stall=1 for 3 cycles while inputs change to 0x0 -> outputs hold lw values for all 3 cycles.
- Flush: flush=1 one cycle after a valid load -> next cycle all control 0, valid_ex=0, funct_ex=0, bubble_cnt=1. Same edge with stall=1 too -> identical result.
- Saturation: CNT_W=4, 20 consecutive flushes -> bubble_cnt reaches 15 and stays 15.
- Reset mid-operation: reset=1 on the edge where flush=1 and stall=1 -> all outputs 0 and bubble_cnt=0, not 1.
